// File: rtl/seq_mod_reduce_q.sv
// Sequential reducer of a 512-bit product modulo q = 2^255 - 19 (fold x2 at 2^256, fold x2 at 2^255, final subtract).
// Optional macro SEQ_REDUCE_EARLY_DONE_EN skips folds whose input is already in range (data-dependent timing).
module seq_mod_reduce_q (
   input  logic         clk,
   input  logic         rst,
   input  logic [511:0] product,
   input  logic         start,
   output logic [255:0] result,
   output logic         done,
   output logic         busy
);

   localparam int unsigned B  = 256;
   localparam int unsigned B2 = 512;
   localparam int unsigned FW = B + 6;
   localparam int unsigned GW = 12;
   localparam logic [B-1:0] Q = {1'b0, {(B - 6){1'b1}}, 5'b01101};

   typedef enum logic [2:0] {IDLE, F1, F2, G1, G2, SUB} state_t;

   state_t        state, state_n;
   logic [B2-1:0] x, x_n;
   logic [B-1:0]  result_n;
   logic          done_n, busy_n;

   logic [B-1:0]  h;
   logic [FW-1:0] f38;
   logic [6:0]    t;
   logic [GW-1:0] m19;
   logic [B-1:0]  g19;
   logic [B-1:0]  diff;
   logic          ge;

   // Both folds and the final subtract are evaluated every cycle; the FSM only muxes.
   always_comb begin : datapath
      h    = x[B2-1:B];
      f38  = FW'(x[B-1:0]) + (FW'(h) << 5) + (FW'(h) << 2) + (FW'(h) << 1);
      t    = x[261:255];
      m19  = (GW'(t) << 4) + (GW'(t) << 1) + GW'(t);
      g19  = B'(x[B-2:0]) + B'(m19);
      ge   = (x[B-1:0] >= Q);
      diff = x[B-1:0] - Q;
   end

`ifdef SEQ_REDUCE_EARLY_DONE_EN
   // Entering G1: nothing above bit 254 means both 2^255 folds are no-ops.
   function automatic state_t g_entry(input logic [B2-1:0] v);
      return (v[B2-1:B-1] == '0) ? SUB : G1;
   endfunction

   // Entering a 2^256 fold: skip straight on to the 2^255 stage when the high half is zero.
   function automatic state_t f_entry(input logic [B2-1:0] v, input state_t fold_st);
      return (v[B2-1:B] == '0) ? g_entry(v) : fold_st;
   endfunction
`endif

   always_comb begin : fsm_next
      state_n  = state;
      x_n      = x;
      result_n = result;
      done_n   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               x_n = product;
`ifdef SEQ_REDUCE_EARLY_DONE_EN
               state_n = f_entry(product, F1);
`else
               state_n = F1;
`endif
            end
         end
         F1: begin
            x_n = B2'(f38);
`ifdef SEQ_REDUCE_EARLY_DONE_EN
            state_n = f_entry(B2'(f38), F2);
`else
            state_n = F2;
`endif
         end
         F2: begin
            x_n = B2'(f38);
`ifdef SEQ_REDUCE_EARLY_DONE_EN
            state_n = g_entry(B2'(f38));
`else
            state_n = G1;
`endif
         end
         G1: begin
            x_n     = B2'(g19);
            state_n = G2;
         end
         G2: begin
            x_n     = B2'(g19);
            state_n = SUB;
         end
         SUB: begin
            result_n = ge ? diff : x[B-1:0];
            done_n   = 1'b1;
            state_n  = IDLE;
         end
         default: state_n = IDLE;
      endcase
      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         x      <= '0;
         result <= '0;
         done   <= 1'b0;
         busy   <= 1'b0;
      end else begin
         state  <= state_n;
         x      <= x_n;
         result <= result_n;
         done   <= done_n;
         busy   <= busy_n;
      end
   end

endmodule

// File: tb/tb_seq_mod_reduce_q.sv
// Scoreboard bench for seq_mod_reduce_q: expected residue and latency queued at each accept, checked on done.
module tb_seq_mod_reduce_q;

`ifdef SEQ_REDUCE_EARLY_DONE_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [511:0] product;
   logic [255:0] result;
   logic         done;
   logic         busy;

   always #5 clk = ~clk;

   seq_mod_reduce_q dut (
      .clk     (clk),
      .rst     (rst_n),
      .product (product),
      .start   (start),
      .result  (result),
      .done    (done),
      .busy    (busy)
   );

   typedef struct {
      logic [255:0] res;
      int           lat;
      int           acc;
   } exp_t;

   exp_t         sb[$];
   int           n_cmp = 0;
   int           n_err = 0;
   int           cyc = 0;
   int           cnt = 0;
   int           done_cnt = 0;
   logic [255:0] exp_next;
   int           lat_next;
   logic [511:0] qv;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected clocks from accept to done, derived arithmetically from the value ranges.
   function automatic int model_lat(input logic [511:0] p);
      logic [519:0] v;
      int           l;
      v = 520'(p);
      l = 1;
      if ((v >> 256) != 0) begin
         v = 520'(v[255:0]) + 520'(38) * (v >> 256);
         l++;
         if ((v >> 256) != 0) l++;
      end
      if ((v >> 255) != 0) l += 2;
      return EARLY ? l : 5;
   endfunction

   // Bench-side occupancy model decides which start edges the DUT should accept.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb.delete();
         cnt = 0;
      end else begin
         cyc++;
         if (cnt != 0) cnt--;
         else if (start) begin
            sb.push_back('{exp_next, lat_next, cyc});
            cnt = lat_next;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && done) begin
         exp_t e;
         done_cnt++;
         if (sb.size() == 0) check("spurious_done", 256'(done), 256'(0));
         else begin
            e = sb.pop_front();
            check("result", result, e.res);
            check("latency", 256'(cyc - e.acc), 256'(e.lat));
         end
      end
   end

   task automatic wait_idle();
      int k = 0;
      while (cnt != 0 && k < 40) begin
         @(negedge clk);
         k++;
      end
      if (cnt != 0) check("idle_timeout", 256'(1), 256'(0));
   endtask

   task automatic drain();
      int k = 0;
      while ((sb.size() != 0 || cnt != 0) && k < 60) begin
         @(negedge clk);
         #1;
         k++;
      end
      if (sb.size() != 0 || cnt != 0) check("drain_timeout", 256'(1), 256'(0));
   endtask

   // Drives one accepted request; returns at the falling edge after the accepting edge.
   task automatic launch(input logic [511:0] p, input logic [255:0] exp);
      wait_idle();
      @(negedge clk);
      product  = p;
      exp_next = exp;
      lat_next = model_lat(p);
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      product  = {16{$urandom}};
   endtask

   task automatic reduce(input logic [511:0] p, input logic [255:0] exp, input bit win);
      launch(p, exp);
      if (win && lat_next == 5) begin
         check("busy_e0", 256'(busy), 256'(1));
         for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            check("busy_win", 256'(busy), 256'(1));
            check("done_early", 256'(done), 256'(0));
         end
         @(negedge clk);
         check("busy_end", 256'(busy), 256'(0));
      end
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int d0;
      int nexp;
      logic [511:0] pmax;
      qv       = (512'd1 << 255) - 512'd19;
      pmax     = '1;
      rst_n    = 1'b0;
      start    = 1'b0;
      product  = '0;
      exp_next = '0;
      lat_next = 5;
      repeat (3) @(negedge clk);
      check("rst_result", result, 256'(0));
      check("rst_done", 256'(done), 256'(0));
      check("rst_busy", 256'(busy), 256'(0));
      rst_n = 1'b1;

      reduce(512'd0, 256'd0, 1'b1);
      reduce(qv - 512'd1, 256'(qv - 512'd1), 1'b1);
      reduce(qv, 256'd0, 1'b0);
      reduce(qv + 512'd5, 256'd5, 1'b0);
      reduce(2 * qv + 512'd7, 256'd7, 1'b0);
      reduce(512'd54 << 255, 256'd1026, 1'b0);
      reduce(pmax, 256'd1443, 1'b0);
      reduce(512'd1 << 256, 256'd38, 1'b0);
      reduce(512'd17, 256'd17, 1'b0);

      // start held high for 12 edges: back-to-back accepts every lat+1 clocks
      wait_idle();
      d0 = done_cnt;
      @(negedge clk);
      product  = qv + 512'd5;
      exp_next = 256'd5;
      lat_next = model_lat(qv + 512'd5);
      nexp     = 11 / (lat_next + 1) + 1;
      start    = 1'b1;
      repeat (12) @(negedge clk);
      start = 1'b0;
      drain();
      check("held_completions", 256'(done_cnt - d0), 256'(nexp));

      // start pulsed mid-flight is ignored
      d0 = done_cnt;
      launch(pmax, 256'd1443);
      @(negedge clk);
      @(negedge clk);
      product  = qv + 512'd5;
      exp_next = 256'd5;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain();
      check("busy_start_ignored", 256'(done_cnt - d0), 256'(1));

      // asynchronous reset in the middle of a reduction
      launch(pmax, 256'd1443);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("arst_result", result, 256'(0));
      check("arst_busy", 256'(busy), 256'(0));
      check("arst_done", 256'(done), 256'(0));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      d0 = done_cnt;
      repeat (8) @(negedge clk);
      check("arst_no_done", 256'(done_cnt - d0), 256'(0));
      reduce(qv + 512'd5, 256'd5, 1'b0);

      check("sb_empty", 256'(sb.size()), 256'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
